// File: rtl/instr_decode_seq.sv
// instr_decode_seq
//   Registered instruction decoder. It accepts one {opcode, reg, data} word
//   over a valid/ready handshake and latches the three fields. A small FSM
//   then drives the accumulator/ALU/branch control strobes. ST waits for a
//   memory acknowledge. RST stretches an active-low soft reset over
//   RST_CYCLES cycles. Undefined opcodes raise a one-cycle illegal flag.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   data_in, in_valid : instruction word and its valid qualifier
//   in_ready          : high only in IDLE (and low while rst is asserted)
//   store_ack         : memory completed the store (only looked at in STORE)
//   opcode/reg_sel/imm: latched instruction fields
//   rst_f             : active-low soft reset to the datapath
//   load, imm_sel     : accumulator load strobe and source (1 = imm)
//   store             : store request, held until acknowledged
//   alu_op            : 00 none, 01 add, 10 sub
//   jump              : branch strobe, target = imm
//   illegal           : one-cycle undefined-opcode flag
//   busy              : decoder is not in IDLE
module instr_decode_seq #(
    parameter int ADDR_WIDTH    = 5,
    parameter int REG_BIT_CNT   = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH,
    parameter int RST_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COMBINED_DATA-1:0] data_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     store_ack,
    output logic [ADDR_WIDTH-1:0]    opcode,
    output logic [REG_BIT_CNT-1:0]   reg_sel,
    output logic [DATA_WIDTH-1:0]    imm,
    output logic                     rst_f,
    output logic                     load,
    output logic                     imm_sel,
    output logic                     store,
    output logic [1:0]               alu_op,
    output logic                     jump,
    output logic                     illegal,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_STORE,
        S_RST_HOLD
    } state_t;

    // Counter must be at least 1 bit wide even when RST_CYCLES == 1.
    localparam int CNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int NUM_OPS = 7;
    localparam int OP_RST  = 0;
    localparam int OP_LDR  = 1;
    localparam int OP_LDI  = 2;
    localparam int OP_ST   = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_JMP  = 6;

    state_t                   state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [ADDR_WIDTH-1:0]    opcode_reg;
    logic [REG_BIT_CNT-1:0]   reg_sel_reg;
    logic [DATA_WIDTH-1:0]    imm_reg;
    logic                     rst_f_reg;
    logic                     load_reg;
    logic                     imm_sel_reg;
    logic                     store_reg;
    logic [1:0]               alu_op_reg;
    logic                     jump_reg;
    logic                     illegal_reg;

    // Field split of the incoming word.
    logic [ADDR_WIDTH-1:0]  fetch_op;
    logic [REG_BIT_CNT-1:0] fetch_reg;
    logic [DATA_WIDTH-1:0]  fetch_imm;

    assign fetch_op  = data_in[COMBINED_DATA-1 -: ADDR_WIDTH];
    assign fetch_reg = data_in[DATA_WIDTH +: REG_BIT_CNT];
    assign fetch_imm = data_in[DATA_WIDTH-1:0];

    // One-hot match of the incoming opcode against each defined opcode.
    // No hit at all means the opcode is illegal.
    logic [NUM_OPS-1:0] op_hit;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_hit
            assign op_hit[gi] = (fetch_op == ADDR_WIDTH'(gi));
        end
    endgenerate

    // All strobes are registered on the transition into their state and
    // cleared on the way out. This keeps them glitch-free and zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            opcode_reg  <= '0;
            reg_sel_reg <= '0;
            imm_reg     <= '0;
            rst_f_reg   <= 1'b1;
            load_reg    <= 1'b0;
            imm_sel_reg <= 1'b0;
            store_reg   <= 1'b0;
            alu_op_reg  <= 2'b00;
            jump_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        opcode_reg  <= fetch_op;
                        reg_sel_reg <= fetch_reg;
                        imm_reg     <= fetch_imm;
                        if (op_hit[OP_RST]) begin
                            state_reg <= S_RST_HOLD;
                            cnt_reg   <= CNT_W'(RST_CYCLES - 1);
                            rst_f_reg <= 1'b0;
                        end else if (op_hit[OP_ST]) begin
                            state_reg <= S_STORE;
                            store_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_EXEC;
                            load_reg    <= op_hit[OP_LDR] | op_hit[OP_LDI];
                            imm_sel_reg <= op_hit[OP_LDI];
                            alu_op_reg  <= {op_hit[OP_SUB], op_hit[OP_ADD]};
                            jump_reg    <= op_hit[OP_JMP];
                            illegal_reg <= ~(|op_hit);
                        end
                    end
                end
                S_EXEC: begin
                    state_reg   <= S_IDLE;
                    load_reg    <= 1'b0;
                    imm_sel_reg <= 1'b0;
                    alu_op_reg  <= 2'b00;
                    jump_reg    <= 1'b0;
                    illegal_reg <= 1'b0;
                end
                S_STORE: begin
                    if (store_ack) begin
                        state_reg <= S_IDLE;
                        store_reg <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    // The counter was loaded with RST_CYCLES-1 on entry. The
                    // exit edge is therefore RST_CYCLES edges after the accept.
                    if (cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                        rst_f_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready also drops while rst is held. busy only reflects the state,
    // so it reads 0 during reset.
    assign in_ready = (state_reg == S_IDLE) & ~rst;
    assign busy     = (state_reg != S_IDLE);

    assign opcode  = opcode_reg;
    assign reg_sel = reg_sel_reg;
    assign imm     = imm_reg;
    assign rst_f   = rst_f_reg;
    assign load    = load_reg;
    assign imm_sel = imm_sel_reg;
    assign store   = store_reg;
    assign alu_op  = alu_op_reg;
    assign jump    = jump_reg;
    assign illegal = illegal_reg;

endmodule
